// File: rtl/conv_pe_scheduler_pkg.sv
// Shared types and defaults for the convolution PE scheduler.
// TIMEOUT_LIMIT is only used when CONV_SCHED_TIMEOUT_EN is defined.
package conv_pe_scheduler_pkg;
   localparam int PKG_NUM_PE = 16;
   localparam int PKG_ADDR_W = 20;
   localparam int PKG_NF_W   = 12;
   localparam logic [15:0] TIMEOUT_LIMIT = 16'hFFFF;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RUN      = 3'd1,
      ST_WAIT_FIN = 3'd2,
      ST_REPORT   = 3'd3,
      ST_DONE     = 3'd4
   } state_e;
endpackage

// File: rtl/conv_pe_scheduler_if.sv
// Layer-control / PE-array bundle for conv_pe_scheduler.
// The slave modport is the scheduler side; the master modport is the layer controller and PE array side.
interface conv_pe_scheduler_if
   import conv_pe_scheduler_pkg::*;
#(
   parameter int NUM_PE = PKG_NUM_PE,
   parameter int ADDR_W = PKG_ADDR_W,
   parameter int NF_W   = PKG_NF_W
);
   logic                     start;
   logic                     abort;
   logic [ADDR_W-1:0]        cfg_base_addr;
   logic [ADDR_W-1:0]        cfg_kernel_len;
   logic [NF_W-1:0]          cfg_num_filters;
   logic [NUM_PE-1:0]        PE_finish;
   logic [NUM_PE-1:0]        PE_en;
   logic [NUM_PE*ADDR_W-1:0] addr_w;
   logic                     busy;
   logic                     ofm_valid;
   logic [NUM_PE-1:0]        ofm_mask;
   logic [NF_W-1:0]          pass_idx;
   logic                     done;
   logic                     timeout;

   modport master (
      output start, abort, cfg_base_addr, cfg_kernel_len, cfg_num_filters, PE_finish,
      input  PE_en, addr_w, busy, ofm_valid, ofm_mask, pass_idx, done, timeout
   );

   modport slave (
      input  start, abort, cfg_base_addr, cfg_kernel_len, cfg_num_filters, PE_finish,
      output PE_en, addr_w, busy, ofm_valid, ofm_mask, pass_idx, done, timeout
   );
endinterface

// File: rtl/conv_pe_scheduler_addr_gen.sv
// Per-PE weight address generator: base registers advance by NUM_PE*kernel_len per pass.
// Within a pass each active address simply increments, so the k loop has no multiplier.
module conv_pe_addr_gen #(
   parameter int NUM_PE = 16,
   parameter int ADDR_W = 20
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_load_first,
   input  logic                     i_load_next,
   input  logic                     i_step,
   input  logic [ADDR_W-1:0]        i_base,
   input  logic [ADDR_W-1:0]        i_kl,
   input  logic [NUM_PE-1:0]        i_mask,
   output logic                     o_last,
   output logic [NUM_PE*ADDR_W-1:0] o_addr
);
   logic [ADDR_W-1:0] r_base [NUM_PE];
   logic [ADDR_W-1:0] r_addr [NUM_PE];
   logic [ADDR_W-1:0] w_load [NUM_PE];
   logic [NUM_PE-1:0] r_act;
   logic [ADDR_W-1:0] r_k;
   logic [ADDR_W-1:0] w_stride;

   // Start address of each PE for the pass being entered.
   always_comb begin
      w_stride = ADDR_W'(NUM_PE) * i_kl;
      for (int i = 0; i < NUM_PE; i++) begin
         if (i_load_first) begin
            w_load[i] = i_base + ADDR_W'(i) * i_kl;
         end else begin
            w_load[i] = r_base[i] + w_stride;
         end
      end
   end

   // Base, address and k registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_k   <= {ADDR_W{1'b0}};
         r_act <= {NUM_PE{1'b0}};
         for (int i = 0; i < NUM_PE; i++) begin
            r_base[i] <= {ADDR_W{1'b0}};
            r_addr[i] <= {ADDR_W{1'b0}};
         end
      end else if (i_load_first || i_load_next) begin
         r_k   <= {ADDR_W{1'b0}};
         r_act <= i_mask;
         for (int i = 0; i < NUM_PE; i++) begin
            r_base[i] <= w_load[i];
            r_addr[i] <= i_mask[i] ? w_load[i] : {ADDR_W{1'b0}};
         end
      end else if (i_step) begin
         r_k <= r_k + ADDR_W'(1);
         for (int i = 0; i < NUM_PE; i++) begin
            r_addr[i] <= r_act[i] ? r_addr[i] + ADDR_W'(1) : {ADDR_W{1'b0}};
         end
      end
   end

   assign o_last = (r_k == i_kl - ADDR_W'(1));

   for (genvar g = 0; g < NUM_PE; g++) begin : g_flat
      assign o_addr[g*ADDR_W +: ADDR_W] = r_addr[g];
   end
endmodule

// File: rtl/conv_pe_scheduler.sv
// Splits a conv layer into passes of up to NUM_PE filters, sequences PE enables/addresses and completions.
// Optional watchdog on the completion wait: define CONV_SCHED_TIMEOUT_EN.
module conv_pe_scheduler
   import conv_pe_scheduler_pkg::*;
#(
   parameter int NUM_PE = PKG_NUM_PE,
   parameter int ADDR_W = PKG_ADDR_W,
   parameter int NF_W   = PKG_NF_W
) (
   input logic                clk,
   input logic                reset,
   conv_pe_scheduler_if.slave bus
);
   localparam int FW = NF_W + 1;

   state_e            r_state, w_next_raw, w_next;
   logic [ADDR_W-1:0] r_kl, w_kl;
   logic [NF_W-1:0]   r_nf, w_nf, r_pass_idx;
   logic [FW-1:0]     r_first, w_next_first;
   logic [NUM_PE-1:0] r_mask, r_fin, w_next_mask, r_pe_en, r_ofm_mask;
   logic              r_busy, r_ofm_valid, r_done;
   logic              w_zero_work, w_more, w_fin_all, w_last, w_abort;
   logic              w_enter_run, w_load_first, w_load_next, w_step;
`ifdef CONV_SCHED_TIMEOUT_EN
   logic [15:0]       r_wd;
   logic              r_timeout, w_timeout_hit;
`endif

   // Pass bookkeeping: filter index of PE 0 and the active mask of the next pass.
   always_comb begin
      w_kl         = (r_state == ST_IDLE) ? bus.cfg_kernel_len : r_kl;
      w_nf         = (r_state == ST_IDLE) ? bus.cfg_num_filters : r_nf;
      w_zero_work  = (bus.cfg_num_filters == {NF_W{1'b0}}) || (bus.cfg_kernel_len == {ADDR_W{1'b0}});
      w_more       = ((r_first + FW'(NUM_PE)) < {1'b0, r_nf});
      w_fin_all    = (((r_fin | bus.PE_finish) & r_mask) == r_mask);
      w_next_first = (r_state == ST_IDLE) ? {FW{1'b0}} : r_first + FW'(NUM_PE);
      for (int i = 0; i < NUM_PE; i++) begin
         w_next_mask[i] = ((w_next_first + FW'(i)) < {1'b0, w_nf});
      end
   end

   // Next-state logic; abort overrides every non-idle transition.
   always_comb begin
      w_next_raw = r_state;
`ifdef CONV_SCHED_TIMEOUT_EN
      w_timeout_hit = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_next_raw = w_zero_work ? ST_DONE : ST_RUN;
            end else begin
               w_next_raw = ST_IDLE;
            end
         end
         ST_RUN:  w_next_raw = w_last ? ST_WAIT_FIN : ST_RUN;
         ST_WAIT_FIN: begin
            if (w_fin_all) begin
               w_next_raw = ST_REPORT;
`ifdef CONV_SCHED_TIMEOUT_EN
            end else if (r_wd == TIMEOUT_LIMIT - 16'd1) begin
               w_next_raw    = ST_IDLE;
               w_timeout_hit = 1'b1;
`endif
            end else begin
               w_next_raw = ST_WAIT_FIN;
            end
         end
         ST_REPORT: w_next_raw = w_more ? ST_RUN : ST_DONE;
         ST_DONE:   w_next_raw = ST_IDLE;
         default:   w_next_raw = ST_IDLE;
      endcase
      w_abort      = bus.abort && (r_state != ST_IDLE);
      w_next       = w_abort ? ST_IDLE : w_next_raw;
      w_enter_run  = (w_next == ST_RUN) && (r_state != ST_RUN);
      w_load_first = w_enter_run && (r_state == ST_IDLE);
      w_load_next  = w_enter_run && (r_state == ST_REPORT);
      w_step       = (r_state == ST_RUN) && (w_next == ST_RUN);
   end

   // State, latched configuration and registered outputs, all derived from the next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_kl        <= {ADDR_W{1'b0}};
         r_nf        <= {NF_W{1'b0}};
         r_first     <= {FW{1'b0}};
         r_mask      <= {NUM_PE{1'b0}};
         r_fin       <= {NUM_PE{1'b0}};
         r_pe_en     <= {NUM_PE{1'b0}};
         r_ofm_mask  <= {NUM_PE{1'b0}};
         r_pass_idx  <= {NF_W{1'b0}};
         r_busy      <= 1'b0;
         r_ofm_valid <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_busy      <= (w_next == ST_RUN) || (w_next == ST_WAIT_FIN) || (w_next == ST_REPORT);
         r_ofm_valid <= (w_next == ST_REPORT);
         r_ofm_mask  <= (w_next == ST_REPORT) ? r_mask : {NUM_PE{1'b0}};
         r_done      <= (w_next == ST_DONE);
         if (w_enter_run) begin
            r_pe_en <= w_next_mask;
         end else if (w_next == ST_RUN) begin
            r_pe_en <= r_mask;
         end else begin
            r_pe_en <= {NUM_PE{1'b0}};
         end
         if ((r_state == ST_IDLE) && bus.start) begin
            r_kl       <= bus.cfg_kernel_len;
            r_nf       <= bus.cfg_num_filters;
            r_pass_idx <= {NF_W{1'b0}};
         end else if (w_load_next) begin
            r_pass_idx <= r_pass_idx + NF_W'(1);
         end
         // Completions only count from RUN entry of the current pass.
         if (w_enter_run) begin
            r_first <= w_next_first;
            r_mask  <= w_next_mask;
            r_fin   <= {NUM_PE{1'b0}};
         end else if ((r_state == ST_RUN) || (r_state == ST_WAIT_FIN)) begin
            r_fin <= r_fin | bus.PE_finish;
         end
      end
   end

`ifdef CONV_SCHED_TIMEOUT_EN
   // Watchdog on the completion wait; timeout flag is sticky until the next accepted start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wd      <= 16'd0;
         r_timeout <= 1'b0;
      end else begin
         r_wd <= (r_state == ST_WAIT_FIN) ? r_wd + 16'd1 : 16'd0;
         if ((r_state == ST_IDLE) && bus.start) begin
            r_timeout <= 1'b0;
         end else if (w_timeout_hit && !w_abort) begin
            r_timeout <= 1'b1;
         end
      end
   end
   assign bus.timeout = r_timeout;
`else
   assign bus.timeout = 1'b0;
`endif

   conv_pe_addr_gen #(
      .NUM_PE (NUM_PE),
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .clk          (clk),
      .reset        (reset),
      .i_load_first (w_load_first),
      .i_load_next  (w_load_next),
      .i_step       (w_step),
      .i_base       (bus.cfg_base_addr),
      .i_kl         (w_kl),
      .i_mask       (w_next_mask),
      .o_last       (w_last),
      .o_addr       (bus.addr_w)
   );

   assign bus.PE_en     = r_pe_en;
   assign bus.busy      = r_busy;
   assign bus.ofm_valid = r_ofm_valid;
   assign bus.ofm_mask  = r_ofm_mask;
   assign bus.pass_idx  = r_pass_idx;
   assign bus.done      = r_done;
endmodule

// File: tb/tb_conv_pe_scheduler.sv
// Self-checking bench for conv_pe_scheduler: randomized layers against a pass-level reference model.
module tb_conv_pe_scheduler;
   localparam int NPE = 16;
   localparam int AW  = 20;
   localparam int NW  = 12;
   typedef logic [NPE*AW-1:0] val_t;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_pass   = 0;

   conv_pe_scheduler_if #(.NUM_PE(NPE), .ADDR_W(AW), .NF_W(NW)) bus_if ();

   conv_pe_scheduler #(.NUM_PE(NPE), .ADDR_W(AW), .NF_W(NW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input val_t got, input val_t exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected flat address bus: active PE i of pass p at element k is base + (p*NPE+i)*kl + k mod 2^AW.
   function automatic val_t exp_addr(input logic [AW-1:0] base, input logic [AW-1:0] kl,
                                     input int p, input logic [NPE-1:0] mask, input int k);
      val_t v;
      longint unsigned a;
      v = '0;
      for (int i = 0; i < NPE; i++) begin
         if (mask[i]) begin
            a = 64'(base) + 64'(p * NPE + i) * 64'(kl) + 64'(k);
            v[i*AW +: AW] = a[AW-1:0];
         end
      end
      return v;
   endfunction

   // mode 0: random finishes plus junk start/cfg; mode 1: PE 5 finishes 7 cycles after the rest, junk on PE 15.
   task automatic run_layer(input logic [AW-1:0] base, input logic [AW-1:0] kl,
                            input logic [NW-1:0] nf, input int mode);
      int np, fmax, rep, kli;
      int f [NPE];
      logic [NPE-1:0] mask, fin, e_en;
      val_t ea;
      kli = int'(kl);
      bus_if.cfg_base_addr   = base;
      bus_if.cfg_kernel_len  = kl;
      bus_if.cfg_num_filters = nf;
      bus_if.start           = 1'b1;
      @(negedge clk);
      bus_if.start = 1'b0;
      if (nf == '0 || kl == '0) begin
         check_eq("zero_done", val_t'(bus_if.done), val_t'(1'b1));
         check_eq("zero_pe_en", val_t'(bus_if.PE_en), val_t'(0));
         check_eq("zero_busy", val_t'(bus_if.busy), val_t'(0));
         check_eq("zero_ofm", val_t'(bus_if.ofm_valid), val_t'(0));
         @(negedge clk);
         check_eq("zero_done_clr", val_t'(bus_if.done), val_t'(0));
         check_eq("zero_pe_en2", val_t'(bus_if.PE_en), val_t'(0));
         return;
      end
      np = (int'(nf) + NPE - 1) / NPE;
      ea = '0;
      for (int p = 0; p < np; p++) begin
         mask = '0;
         fmax = 0;
         for (int i = 0; i < NPE; i++) begin
            mask[i] = ((p * NPE + i) < int'(nf));
            if (mode == 1) f[i] = (i == 5) ? kli + 8 : kli + 1;
            else           f[i] = int'($urandom_range(kli + 6, 0));
            if (mask[i] && f[i] > fmax) fmax = f[i];
         end
         rep = ((fmax > kli) ? fmax : kli) + 1;
         for (int c = 0; c <= rep; c++) begin
            if (c < kli) ea = exp_addr(base, kl, p, mask, c);
            e_en = (c < kli) ? mask : '0;
            check_eq($sformatf("p%0d c%0d pe_en", p, c), val_t'(bus_if.PE_en), val_t'(e_en));
            check_eq($sformatf("p%0d c%0d busy", p, c), val_t'(bus_if.busy), val_t'(1'b1));
            check_eq($sformatf("p%0d c%0d ofm_valid", p, c), val_t'(bus_if.ofm_valid), val_t'(c == rep));
            check_eq($sformatf("p%0d c%0d ofm_mask", p, c), val_t'(bus_if.ofm_mask),
                     val_t'((c == rep) ? mask : '0));
            check_eq($sformatf("p%0d c%0d pass_idx", p, c), val_t'(bus_if.pass_idx), val_t'(p));
            check_eq($sformatf("p%0d c%0d done", p, c), val_t'(bus_if.done), val_t'(0));
            check_eq($sformatf("p%0d c%0d timeout", p, c), val_t'(bus_if.timeout), val_t'(0));
            check_eq($sformatf("p%0d c%0d addr_w", p, c), bus_if.addr_w, ea);
            fin = '0;
            for (int i = 0; i < NPE; i++) begin
               if (mask[i]) fin[i] = (f[i] == c);
               else         fin[i] = ($urandom_range(3, 0) == 0);
            end
            if (mode == 1 && c == 2) fin[15] = 1'b1;
            bus_if.PE_finish = fin;
            if (mode == 0) begin
               bus_if.start           = ($urandom_range(7, 0) == 0);
               bus_if.cfg_base_addr   = AW'($urandom);
               bus_if.cfg_kernel_len  = AW'($urandom);
               bus_if.cfg_num_filters = NW'($urandom);
            end
            @(negedge clk);
         end
      end
      bus_if.PE_finish = '0;
      bus_if.start     = 1'b0;
      check_eq("layer_done", val_t'(bus_if.done), val_t'(1'b1));
      check_eq("done_busy", val_t'(bus_if.busy), val_t'(0));
      check_eq("done_pe_en", val_t'(bus_if.PE_en), val_t'(0));
      check_eq("done_ofm", val_t'(bus_if.ofm_valid), val_t'(0));
      @(negedge clk);
      check_eq("done_clr", val_t'(bus_if.done), val_t'(0));
      check_eq("idle_busy", val_t'(bus_if.busy), val_t'(0));
   endtask

   task automatic run_abort();
      bus_if.cfg_base_addr   = AW'($urandom);
      bus_if.cfg_kernel_len  = 20'd10;
      bus_if.cfg_num_filters = 12'd32;
      bus_if.start           = 1'b1;
      @(negedge clk);
      bus_if.start = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check_eq($sformatf("abort_run c%0d pe_en", c), val_t'(bus_if.PE_en), val_t'(16'hFFFF));
         if (c == 2) bus_if.abort = 1'b1;
         @(negedge clk);
      end
      bus_if.abort = 1'b0;
      check_eq("abort_pe_en", val_t'(bus_if.PE_en), val_t'(0));
      check_eq("abort_busy", val_t'(bus_if.busy), val_t'(0));
      for (int c = 0; c < 20; c++) begin
         check_eq($sformatf("abort_quiet c%0d", c), val_t'({bus_if.done, bus_if.ofm_valid}), val_t'(0));
         @(negedge clk);
      end
   endtask

   initial begin
      reset                  = 1'b1;
      bus_if.start           = 1'b0;
      bus_if.abort           = 1'b0;
      bus_if.cfg_base_addr   = '0;
      bus_if.cfg_kernel_len  = '0;
      bus_if.cfg_num_filters = '0;
      bus_if.PE_finish       = '0;
      repeat (2) @(negedge clk);
      check_eq("rst_pe_en", val_t'(bus_if.PE_en), val_t'(0));
      check_eq("rst_addr_w", bus_if.addr_w, val_t'(0));
      check_eq("rst_busy", val_t'(bus_if.busy), val_t'(0));
      check_eq("rst_ofm_valid", val_t'(bus_if.ofm_valid), val_t'(0));
      check_eq("rst_ofm_mask", val_t'(bus_if.ofm_mask), val_t'(0));
      check_eq("rst_pass_idx", val_t'(bus_if.pass_idx), val_t'(0));
      check_eq("rst_done", val_t'(bus_if.done), val_t'(0));
      check_eq("rst_timeout", val_t'(bus_if.timeout), val_t'(0));
      reset = 1'b0;
      @(negedge clk);
      check_eq("post_rst_busy", val_t'(bus_if.busy), val_t'(0));

      run_layer(20'h00100, 20'd9, 12'd16, 0);
      run_layer(20'h00100, 20'd4, 12'd20, 0);
      run_layer(20'hFFFF8, 20'd16, 12'd16, 0);
      run_layer(AW'($urandom), 20'd5, 12'd15, 1);
      run_layer(AW'($urandom), 20'd7, 12'd0, 0);
      run_layer(AW'($urandom), 20'd0, 12'd5, 0);
      run_abort();
      run_layer(AW'($urandom), 20'd3, 12'd17, 0);
      repeat (6) begin
         run_layer(AW'($urandom), AW'($urandom_range(12, 1)), NW'($urandom_range(40, 1)), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/conv_pe_scheduler.md
# conv_pe_scheduler

Sequencer for the 16-PE convolution array: splits a layer of `cfg_num_filters` filters into passes of up to NUM_PE filters, drives each PE's enable and weight-address stream, collects PE completions, and signals when each pass's OFM bytes are valid. Sits between the layer control FSM and the convolution sub-top, feeding its `PE_en`, `addr_w*` and consuming `PE_finish`.

## Interface
Parameters:
- NUM_PE, 16, number of PEs driven
- ADDR_W, 20, weight address width per PE
- NF_W, 12, width of filter count

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin layer; sampled only in IDLE
- abort  in  1  synchronous abort to IDLE, no done
- cfg_base_addr  in  ADDR_W  weight address of filter 0, element 0
- cfg_kernel_len  in  ADDR_W  weights (MAC cycles) per filter
- cfg_num_filters  in  NF_W  total filters in layer
- PE_finish  in  NUM_PE  per-PE completion pulse/level
- PE_en  out  NUM_PE  per-PE MAC enable
- addr_w  out  NUM_PE*ADDR_W  flattened weight addresses, PE i at [i*ADDR_W +: ADDR_W]
- busy  out  1  layer in progress
- ofm_valid  out  1  one-cycle pulse, pass results ready
- ofm_mask  out  NUM_PE  PEs holding valid OFM in this pass
- pass_idx  out  NF_W  current pass number
- done  out  1  one-cycle pulse, layer complete
- timeout  out  1  watchdog fired (only with CONV_SCHED_TIMEOUT_EN)

## Operation
- States: IDLE, RUN, WAIT_FIN, REPORT, DONE.
- IDLE: start=1 latches cfg_*; if cfg_num_filters==0 or cfg_kernel_len==0 -> DONE, else RUN with pass 0, k=0.
- Active mask for pass p: bit i set iff p*NUM_PE+i < num_filters (last pass partial).
- RUN: PE_en = mask; addr_w[i] = base + (p*NUM_PE+i)*kernel_len + k, modulo 2^ADDR_W (wrap silently); inactive PEs hold addr 0. k increments each cycle; after k==kernel_len-1 -> WAIT_FIN.
- Sticky fin register cleared on RUN entry, ORs in PE_finish from RUN entry onward; bits outside mask ignored.
- WAIT_FIN: PE_en=0, addr_w holds last value. When (fin & mask)==mask -> REPORT.
- REPORT: ofm_valid=1, ofm_mask=mask for one cycle; then RUN for pass p+1 if (p+1)*NUM_PE < num_filters, else DONE.
- DONE: done=1 one cycle -> IDLE.
- abort in any non-IDLE state: next state IDLE, PE_en cleared, no ofm_valid/done.
- start while busy ignored; cfg changes after start ignored.
- Addresses computed incrementally (per-PE base register + k), no multiplier in the k loop.

## Timing
- Reset: PE_en=0, addr_w=0, busy=0, ofm_valid=0, ofm_mask=0, pass_idx=0, done=0, timeout=0, state IDLE.
- start at cycle t -> busy=1, PE_en=mask, k=0 addresses at t+1.
- RUN lasts exactly cfg_kernel_len cycles per pass.
- PE_finish completing the mask at cycle f (in WAIT_FIN) -> ofm_valid at f+1. Finishes already complete during RUN -> REPORT one cycle after WAIT_FIN entry.
- Next pass PE_en rises cycle after ofm_valid.
- done in cycle after last REPORT; busy=0 in DONE and IDLE.
- Zero-work start: done at t+1, no PE_en, no ofm_valid.

## Configuration
- CONV_SCHED_TIMEOUT_EN defined: 16-bit counter runs in WAIT_FIN; at 65535 cycles without full mask -> timeout=1 (sticky until next start or reset), FSM -> IDLE, no done.
- Undefined: WAIT_FIN waits indefinitely; timeout tied to 0.

## Structure
- Shared package: state enum, NUM_PE/ADDR_W/NF_W defaults, timeout limit constant.
- One sub-module natural: conv_pe_addr_gen (per-PE base registers + k counter producing addr_w).

## Test plan
- base=0x00100, kernel_len=9, num_filters=16 -> one pass; PE_en=0xFFFF for 9 cycles; addr_w[3] runs 0x0011B..0x00123; all PE_finish -> ofm_valid with mask 0xFFFF, then done.
- num_filters=20, kernel_len=4 -> pass 0 mask 0xFFFF, pass 1 mask 0x000F, pass_idx 0 then 1, two ofm_valid pulses, one done.
- base=0xFFFF8, kernel_len=16 -> PE 0 addresses wrap 0xFFFFF -> 0x00000.
- PE_finish staggered (PE 5 last, 7 cycles after others), junk pulse on inactive PE 15 with mask 0x7FFF -> ofm_valid exactly 1 cycle after PE 5.
- num_filters=0 -> done at t+1, PE_en never asserted; abort mid-RUN -> PE_en=0 next cycle, no done.
- With CONV_SCHED_TIMEOUT_EN, PE 2 never finishes -> timeout=1 after 65535 WAIT_FIN cycles, busy=0, no done.
